// File: rtl/plantard_pkg.sv
// Shared constants, mode encoding and a reference model for the Plantard
// modular multiplier (default parameter set: Kyber-style Q = 3329, L = 13).
package plantard_pkg;

  localparam int Q_DEF    = 3329;
  localparam int L_DEF    = 13;
  localparam int W_DEF    = 12;
  localparam int TW_W_DEF = 2 * L_DEF;
  localparam int S_W_DEF  = L_DEF + W_DEF + 1;

  // Q^-1 mod 2^(2L) for the default set; multiplying a twiddle t by this
  // gives the pre-scaled operand the datapath expects.
  localparam logic [TW_W_DEF-1:0] QINV_2L = 26'd61403905;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_BYP = 1'b1
  } mode_e;

  // Behavioural Plantard reduction for the default parameter set:
  // c = -a*t*2^(-2L) mod Q, given tw = t*Q^-1 mod 2^(2L).
  function automatic logic [W_DEF-1:0] plantard_ref(input logic [W_DEF-1:0]    a,
                                                    input logic [TW_W_DEF-1:0] tw);
    logic [TW_W_DEF-1:0] p1;
    logic [L_DEF-1:0]    h;
    logic [S_W_DEF-1:0]  s;
    logic [W_DEF:0]      r;
    p1 = TW_W_DEF'(a) * tw;
    h  = p1[TW_W_DEF-1:L_DEF];
    s  = S_W_DEF'(h) * S_W_DEF'(Q_DEF) + S_W_DEF'(Q_DEF);
    r  = s[S_W_DEF-1:L_DEF];
    return (r == (W_DEF + 1)'(Q_DEF)) ? '0 : r[W_DEF-1:0];
  endfunction

endpackage

// File: rtl/plantard_lane.sv
// One lane of the Plantard multiplier: four register stages, all advancing
// together on en. The mode input is the mode of the beat about to enter S4.
module plantard_lane
  import plantard_pkg::*;
#(
  parameter int data_width = W_DEF,
  parameter int L          = L_DEF,
  parameter int Q          = Q_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic [data_width-1:0] a,
  input  logic [2*L-1:0]        tw,
  output logic [data_width-1:0] c
);

  localparam int TW_W = 2 * L;
  localparam int HQ_W = L + data_width;
  localparam int S_W  = L + data_width + 1;
  localparam int R_W  = data_width + 1;

  // r lies in [0, Q]; the single value Q is folded back to zero.
  function automatic logic [data_width-1:0] fold_q(input logic [R_W-1:0] r);
    return (r == R_W'(Q)) ? '0 : r[data_width-1:0];
  endfunction

  logic [L-1:0]          h;
  logic [HQ_W-1:0]       hq;
  logic [R_W-1:0]        r;

  logic [L-1:0]          h_p1;
  logic [data_width-1:0] a_p1;
  logic [HQ_W-1:0]       hq_p2;
  logic [data_width-1:0] a_p2;
  logic [R_W-1:0]        r_p3;
  logic [data_width-1:0] a_p3;
  logic [data_width-1:0] c_p4;

  // The product is taken mod 2^(2L) and only its upper half is ever used,
  // so S1 keeps just h instead of the full p1.
  assign h  = L'((TW_W'(a) * tw) >> L);
  assign hq = HQ_W'(h_p1) * HQ_W'(Q);
  // s = h*Q + Q needs L+W+1 bits; only s >> L is kept in S3.
  assign r  = R_W'((S_W'(hq_p2) + S_W'(Q)) >> L);

  // S1: upper half of a*tw, operand a carried for bypass
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_p1 <= '0;
      a_p1 <= '0;
    end else if (en) begin
      h_p1 <= h;
      a_p1 <= a;
    end
  end

  // S2: h*Q
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hq_p2 <= '0;
      a_p2  <= '0;
    end else if (en) begin
      hq_p2 <= hq;
      a_p2  <= a_p1;
    end
  end

  // S3: (h*Q + Q) >> L
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p3 <= '0;
      a_p3 <= '0;
    end else if (en) begin
      r_p3 <= r;
      a_p3 <= a_p2;
    end
  end

  // S4: final fold or bypass selection, drives the lane output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_p4 <= '0;
    end else if (en) begin
      c_p4 <= (mode_e'(mode) == MODE_BYP) ? a_p3 : fold_q(r_p3);
    end
  end

  assign c = c_p4;

endmodule

// File: rtl/plantard_mm_pipe.sv
// Multi-lane Plantard modular multiplier with valid/ready handshake. Lanes
// run lock-step; valid, mode and tag travel in a parallel control pipeline,
// and a single global enable stalls every stage when the output is blocked.
module plantard_mm_pipe
  import plantard_pkg::*;
#(
  parameter int data_width = W_DEF,
  parameter int L          = L_DEF,
  parameter int Q          = Q_DEF,
  parameter int N_LANES    = 2,
  parameter int TAG_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_mode,
  input  logic [TAG_W-1:0]              in_tag,
  input  logic [N_LANES*data_width-1:0] in_a,
  input  logic [N_LANES*2*L-1:0]        in_tw,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [TAG_W-1:0]              out_tag,
  output logic [N_LANES*data_width-1:0] out_c
);

  localparam int TW_W = 2 * L;

  if (Q >= (1 << (L - 1))) begin : g_bad_q_l
    $fatal(1, "plantard_mm_pipe: Q must be below 2^(L-1)");
  end
  if (Q >= (1 << data_width)) begin : g_bad_q_w
    $fatal(1, "plantard_mm_pipe: Q must be below 2^data_width");
  end

  logic             en;
  logic             vld_p1, vld_p2, vld_p3, vld_p4;
  logic             mode_p1, mode_p2, mode_p3;
  logic [TAG_W-1:0] tag_p1, tag_p2, tag_p3, tag_p4;

  // Everything advances unless a finished beat is waiting on a busy sink.
  assign en        = !vld_p4 || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_p4;
  assign out_tag   = tag_p4;

  // Valid bits: S1 captures the handshake, bubbles shift like beats
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
      vld_p4 <= 1'b0;
    end else if (en) begin
      vld_p1 <= in_valid;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      vld_p4 <= vld_p3;
    end
  end

  // Per-beat sideband: mode is needed up to the S4 select, tag to the output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_p1 <= 1'b0;
      mode_p2 <= 1'b0;
      mode_p3 <= 1'b0;
      tag_p1  <= '0;
      tag_p2  <= '0;
      tag_p3  <= '0;
      tag_p4  <= '0;
    end else if (en) begin
      mode_p1 <= in_mode;
      mode_p2 <= mode_p1;
      mode_p3 <= mode_p2;
      tag_p1  <= in_tag;
      tag_p2  <= tag_p1;
      tag_p3  <= tag_p2;
      tag_p4  <= tag_p3;
    end
  end

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    plantard_lane #(
      .data_width(data_width),
      .L         (L),
      .Q         (Q)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .mode(mode_p3),
      .a   (in_a[i*data_width +: data_width]),
      .tw  (in_tw[i*TW_W +: TW_W]),
      .c   (out_c[i*data_width +: data_width])
    );
  end

endmodule

// File: tb/tb_plantard_mm_pipe.sv
// Directed bench for plantard_mm_pipe: default 2-lane build, a 4-lane build
// sharing the same handshake, and a Q=7681/L=14 single-lane build.
module tb_plantard_mm_pipe;
  import plantard_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_mode = 1'b0;
  logic         out_ready = 1'b1;
  logic [7:0]   in_tag = '0;
  logic [47:0]  in_a4 = '0;
  logic [103:0] in_tw4 = '0;
  logic [12:0]  in_a7 = 13'd1;
  logic [27:0]  in_tw7 = 28'd193192449;

  logic         in_ready, out_valid;
  logic [7:0]   out_tag;
  logic [23:0]  out_c;
  logic         in_ready4, out_valid4;
  logic [3:0]   out_tag4;
  logic [47:0]  out_c4;
  logic         in_ready7, out_valid7;
  logic [3:0]   out_tag7;
  logic [12:0]  out_c7;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic        v;
    logic        mode;
    logic [7:0]  tag;
    logic [47:0] c;
  } slot_t;

  slot_t       m [4];
  logic [47:0] beat_c = '0;

  always #5 clk = ~clk;

  plantard_mm_pipe #(.N_LANES(2), .TAG_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_tag(in_tag), .in_a(in_a4[23:0]), .in_tw(in_tw4[51:0]), .out_valid(out_valid),
    .out_ready(out_ready), .out_tag(out_tag), .out_c(out_c)
  );

  plantard_mm_pipe #(.N_LANES(4), .TAG_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_mode(in_mode),
    .in_tag(in_tag[3:0]), .in_a(in_a4), .in_tw(in_tw4), .out_valid(out_valid4),
    .out_ready(out_ready), .out_tag(out_tag4), .out_c(out_c4)
  );

  plantard_mm_pipe #(.data_width(13), .L(14), .Q(7681), .N_LANES(1), .TAG_W(4)) dut7 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready7), .in_mode(in_mode),
    .in_tag(in_tag[3:0]), .in_a(in_a7), .in_tw(in_tw7), .out_valid(out_valid7),
    .out_ready(out_ready), .out_tag(out_tag7), .out_c(out_c7)
  );

  // Independent arithmetic model: -a*t*2^-26 mod 3329 via Plantard steps.
  function automatic logic [11:0] tb_ref(input logic [11:0] a, input logic [25:0] tw);
    longint unsigned p, h, r;
    p = 64'(a) * 64'(tw);
    p = p % 64'd67108864;
    h = p >> 13;
    r = (h * 64'd3329 + 64'd3329) >> 13;
    return (r == 64'd3329) ? 12'd0 : 12'(r);
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  // Present one beat on the inputs; expected lane results come from the model.
  task automatic set_beat(input logic v, input logic mode, input logic [7:0] tag,
                          input logic [47:0] a4, input logic [103:0] tw4);
    in_valid = v;
    in_mode  = mode;
    in_tag   = tag;
    in_a4    = a4;
    in_tw4   = tw4;
    for (int k = 0; k < 4; k++)
      beat_c[k*12 +: 12] = mode ? a4[k*12 +: 12] : tb_ref(a4[k*12 +: 12], tw4[k*26 +: 26]);
  endtask

  // One clock: check outputs against the timing model, advance the model, then
  // move to just after the next rising edge for the caller to drive inputs.
  task automatic step();
    logic exp_en;
    @(negedge clk);
    exp_en = !m[3].v || out_ready;
    check("out_valid", 64'(out_valid), 64'(m[3].v));
    check("out_valid4", 64'(out_valid4), 64'(m[3].v));
    check("out_valid7", 64'(out_valid7), 64'(m[3].v));
    check("in_ready", 64'(in_ready), 64'(exp_en));
    check("in_ready4", 64'(in_ready4), 64'(exp_en));
    check("in_ready7", 64'(in_ready7), 64'(exp_en));
    if (m[3].v) begin
      check("out_c", 64'(out_c), 64'(m[3].c[23:0]));
      check("out_tag", 64'(out_tag), 64'(m[3].tag));
      check("out_c4", 64'(out_c4), 64'(m[3].c));
      check("out_tag4", 64'(out_tag4), 64'(m[3].tag[3:0]));
      check("out_c7", 64'(out_c7), m[3].mode ? 64'd1 : 64'd5528);
      check("out_tag7", 64'(out_tag7), 64'(m[3].tag[3:0]));
    end
    if (exp_en) begin
      m[3]      = m[2];
      m[2]      = m[1];
      m[1]      = m[0];
      m[0].v    = in_valid;
      m[0].mode = in_mode;
      m[0].tag  = in_tag;
      m[0].c    = beat_c;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [47:0]  ra;
    logic [103:0] rt;
    int           tag_ctr;
    tag_ctr = 8'h40;
    for (int k = 0; k < 4; k++) m[k] = '0;

    // Reset state
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_c", 64'(out_c), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_out_c4", 64'(out_c4), 64'd0);
    rst = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("pkg_ref", 64'(plantard_ref(12'd1, QINV_2L)), 64'd3046);

    // Single beat: a=1 with tw=Q^-1 -> 3046, a=1 with tw=46063009 -> 2285
    set_beat(1'b1, 1'b0, 8'h11, {12'd0, 12'd0, 12'd1, 12'd1},
             {26'd0, 26'd0, 26'd46063009, 26'd61403905});
    beat_c[23:0] = {12'd2285, 12'd3046};
    step();
    in_valid = 1'b0;
    repeat (5) step();

    // Back-to-back boundary beats: a=0, r==Q fold, bypass, a=Q-1
    set_beat(1'b1, 1'b0, 8'h12, {12'd0, 12'd0, 12'd1, 12'd0},
             {26'd0, 26'd0, 26'h3FFE000, 26'h3FFFFFF});
    beat_c[23:0] = {12'd0, 12'd0};
    step();
    set_beat(1'b1, 1'b1, 8'h13, {12'd5, 12'd3000, 12'd17, 12'd3328},
             {26'd1, 26'd2, 26'd61403905, 26'd61403905});
    beat_c[23:0] = {12'd17, 12'd3328};
    step();
    set_beat(1'b1, 1'b0, 8'h14, {12'd0, 12'd0, 12'd1, 12'd3328},
             {26'd0, 26'd0, 26'd61403905, 26'd61403905});
    beat_c[23:0] = {12'd3046, 12'd283};
    step();
    in_valid = 1'b0;
    repeat (5) step();

    // 64-beat stream, alternating mode, sink always ready
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      for (int k = 0; k < 4; k++) begin
        ra[k*12 +: 12] = 12'($urandom_range(3328, 0));
        rt[k*26 +: 26] = 26'($urandom);
      end
      set_beat(1'b1, 1'(i % 2), 8'(tag_ctr), ra, rt);
      tag_ctr++;
      step();
    end
    in_valid = 1'b0;
    repeat (6) step();

    // Random backpressure with a continuously valid source
    for (int i = 0; i < 100; i++) begin
      for (int k = 0; k < 4; k++) begin
        ra[k*12 +: 12] = 12'($urandom_range(3328, 0));
        rt[k*26 +: 26] = 26'($urandom);
      end
      set_beat(1'b1, 1'($urandom_range(1, 0)), 8'(tag_ctr), ra, rt);
      out_ready = 1'($urandom_range(1, 0));
      tag_ctr++;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) step();

    // Reset with three beats in flight, one of them already at the output
    for (int i = 0; i < 3; i++) begin
      set_beat(1'b1, 1'b0, 8'(8'hA0 + i), {12'd0, 12'd0, 12'd1, 12'd1},
               {26'd0, 26'd0, 26'd61403905, 26'd61403905});
      step();
    end
    in_valid = 1'b0;
    step();
    check("pre_rst_valid", 64'(out_valid), 64'(m[3].v));
    rst = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_valid4", 64'(out_valid4), 64'd0);
    check("async_rst_c", 64'(out_c), 64'd0);
    check("async_rst_tag", 64'(out_tag), 64'd0);
    for (int k = 0; k < 4; k++) m[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    repeat (3) step();
    set_beat(1'b1, 1'b0, 8'h5A, {12'd0, 12'd0, 12'd1, 12'd1},
             {26'd0, 26'd0, 26'd46063009, 26'd61403905});
    beat_c[23:0] = {12'd2285, 12'd3046};
    step();
    in_valid = 1'b0;
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
